// File: rtl/key_scanner_if.sv
// key_scanner_if: button-to-Controller bundle for the key scanner.
//   btnRaw   : raw active-high push-buttons (asynchronous, may bounce)
//   keyPress : one-cycle pulse per accepted press
//   keyType  : encoded code of the accepted button, held until the next pulse
//   keyHeld  : high while the accepted button has not been cleanly released
// master is the scanner side; slave is the button source / Controller side.
interface key_scanner_if;
  logic [3:0] btnRaw;
  logic       keyPress;
  logic [1:0] keyType;
  logic       keyHeld;

  modport master (
    input  btnRaw,
    output keyPress,
    output keyType,
    output keyHeld
  );

  modport slave (
    output btnRaw,
    input  keyPress,
    input  keyType,
    input  keyHeld
  );
endinterface

// File: rtl/key_scanner.sv
// key_scanner: synchronizes and debounces four raw buttons and emits one
// keyPress pulse, with an encoded keyType, per accepted press.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : key_scanner_if.master (btnRaw in; keyPress, keyType, keyHeld out)
module key_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic           clk,
  input logic           rst_n,
  key_scanner_if.master bus
);

  typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRelease} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       syncMeta;
  logic [3:0]       btnSync;
  state_e           state;
  logic [3:0]       cand;
  logic [1:0]       code;
  logic [CNT_W-1:0] cnt;
  logic             keyPressQ;
  logic [1:0]       keyTypeQ;

  // Lowest set bit wins.
  function automatic logic [1:0] encode(input logic [3:0] b);
    if (b[0])      return 2'b00;
    else if (b[1]) return 2'b01;
    else if (b[2]) return 2'b10;
    else           return 2'b11;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= 4'b0;
      btnSync  <= 4'b0;
    end else begin
      syncMeta <= bus.btnRaw;
      btnSync  <= syncMeta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cand      <= 4'b0;
      code      <= 2'b00;
      cnt       <= '0;
      keyPressQ <= 1'b0;
      keyTypeQ  <= 2'b00;
    end else begin
      keyPressQ <= 1'b0;
      unique case (state)
        StIdle: begin
          if (btnSync != 4'b0) begin
            cand  <= btnSync;
            code  <= encode(btnSync);
            cnt   <= '0;
            state <= StDebPress;
          end
        end
        StDebPress: begin
          // Any pattern change (including release) restarts from idle.
          if (btnSync != cand) begin
            state <= StIdle;
          end else if (cnt == CntLast) begin
            keyPressQ <= 1'b1;
            keyTypeQ  <= code;
            state     <= StHeld;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StHeld: begin
          // Extra or changed buttons are ignored until everything is released.
          if (btnSync == 4'b0) begin
            cnt   <= '0;
            state <= StDebRelease;
          end
        end
        StDebRelease: begin
          if (btnSync != 4'b0) begin
            state <= StHeld;
          end else if (cnt == CntLast) begin
            state <= StIdle;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.keyPress = keyPressQ;
  assign bus.keyType  = keyTypeQ;
  assign bus.keyHeld  = (state == StHeld) || (state == StDebRelease);

endmodule

// File: doc/key_scanner.md
# key_scanner

Front-end stage for the memory Controller: samples four raw push-buttons, synchronizes and debounces them, and emits exactly one single-cycle `keyPress` pulse with an encoded `keyType` per accepted press. Its outputs connect directly to the Controller's `keyPress`/`keyType` inputs. Holding a button produces no further pulses; a clean release is required before the next press is accepted.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a press or a release. Legal range is ≥ 2; benches override it to 4.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width. It is derived and is not overridden.

- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btnRaw`  in  4  raw buttons, active-high, asynchronous to `clk`, may bounce.
- `keyPress`  out  1  one-cycle pulse when a press is accepted.
- `keyType`  out  2  code of the accepted button. Holds its value until the next pulse.
- `keyHeld`  out  1  high while the accepted button has not been cleanly released.

## Operation
- **Synchronizer:** two flops on `btnRaw` feed `btnSync[3:0]`. All downstream logic uses only `btnSync`.
- **Encoding:** priority encoder, lowest index wins. bit0 → 2'b00, bit1 → 2'b01, bit2 → 2'b10, bit3 → 2'b11.
- **FSM states:** IDLE, DEB_PRESS, HELD, DEB_RELEASE. Registers: `cand[3:0]`, `code[1:0]`, `cnt[CNT_W-1:0]`.
- **IDLE:**
  - If `btnSync != 0`: `cand <= btnSync`, `code <=` encode(`btnSync`), `cnt <= 0`, go to DEB_PRESS.
  - Otherwise stay in IDLE.
- **DEB_PRESS:**
  - If `btnSync != cand` (including all-zero): go to IDLE, no pulse.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `keyPress <= 1`, `keyType <= code`, go to HELD.
  - Else `cnt <= cnt+1`.
- **HELD:**
  - If `btnSync == 0`: `cnt <= 0`, go to DEB_RELEASE.
  - Any other nonzero pattern, including extra buttons, is ignored.
- **DEB_RELEASE:**
  - If `btnSync != 0`: go to HELD (bounce during release, no pulse).
  - Else if `cnt == DEBOUNCE_CYCLES-1`: go to IDLE.
  - Else `cnt <= cnt+1`.
- **Simultaneous buttons:** the pattern is captured as one candidate. `code` follows the lowest set bit. A pattern change during DEB_PRESS restarts through IDLE.
- **Output rules:**
  - `keyPress` is registered and high for exactly one cycle, on the HELD entry edge only.
  - `keyHeld` is 1 in HELD and DEB_RELEASE, 0 otherwise.
- **Counter:** never wraps, because it is compared against `DEBOUNCE_CYCLES-1` before incrementing.

## Timing
- **Reset values:**
  - Asserting `rst_n` low immediately forces: state IDLE, sync flops 0, `cand` 0, `code` 0, `cnt` 0, `keyPress` 0, `keyType` 2'b00, `keyHeld` 0.
  - Reset mid-debounce or mid-hold produces no pulse, on entry or on exit.
- **Press latency:** `btnRaw` changes before edge 0 and stays stable.
  - `btnSync` is valid after edge 1.
  - IDLE → DEB_PRESS at edge 2.
  - `keyPress` is high for the cycle after edge `DEBOUNCE_CYCLES+2`, and low again after the next edge.
- **`keyType`:** updates on the same edge `keyPress` rises. It is valid whenever `keyPress` is high and stable afterward.
- **Release timing:** after a release stable from edge r, IDLE is re-entered at edge `r+DEBOUNCE_CYCLES+2`. A new press is detected from the following edge.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES+1` synchronized cycles produces no pulse.

## Test plan (DEBOUNCE_CYCLES=4)
1. **Clean press:** `btnRaw`=4'b0100 held 20 cycles from edge 0, then 0 → `keyPress` high exactly once, after edge 6; `keyType`=2'b10; `keyHeld` 1 from edge 6 until 6 edges after release.
2. **Bounce on press:** `btnRaw` toggles 0100/0000 every 2 cycles for 10 cycles, then holds 0100 → no pulse during toggling; one pulse with `keyType`=2'b10 exactly 6 edges after the stable hold begins.
3. **Multi-key:** `btnRaw`=4'b1010 held → single pulse with `keyType`=2'b01. While held, changing to 4'b1000 → no additional pulse.
4. **Release bounce:** press 4'b0001 and accept it; release with 3-cycle low glitches back to 0001; then a clean release → exactly one pulse total (`keyType`=2'b00); `keyHeld` stays 1 through the glitches.
5. **Sequence into Controller:** presses of 0001, 0010, 0100, 1000, each followed by a clean release → four pulses, `keyType` = 00, 01, 10, 11 in order; never two pulses without an intervening IDLE.
6. **Reset mid-operation:** assert `rst_n`=0 during DEB_PRESS, and again during HELD → all outputs 0 at once. After deassertion with the button still held → a fresh press is detected 6 edges later, with one pulse.
